// File: rtl/disp_scan_sched.sv
// Scan scheduler for the 6-digit multiplexed seven-segment display.
// Holds the digit registers, encodes them and hands (seg, sel) words to the 74HC595 serializer.
module disp_scan_sched #(
  parameter int DWELL   = 50000,
  parameter int DWELL_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [5:0] dp_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_seg,
  output logic [5:0] out_sel,
  output logic       frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  localparam logic [4:0]         BLANK      = 5'b1_0000;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [4:0]         digit [6];
  logic [4:0]         cur_digit;
  logic               cur_dp;
  logic [7:0]         seg_next;

  // Active-low {a,b,c,d,e,f,g,dp}; codes 10..15 show "E" so bad data is visible.
  function automatic logic [7:0] encode(input logic [4:0] d);
    logic [7:0] s;
    if (d[4]) begin
      s = 8'hFF;
    end else begin
      case (d[3:0])
        4'd0:    s = 8'h03;
        4'd1:    s = 8'h9F;
        4'd2:    s = 8'h25;
        4'd3:    s = 8'h0D;
        4'd4:    s = 8'h99;
        4'd5:    s = 8'h49;
        4'd6:    s = 8'h41;
        4'd7:    s = 8'h1F;
        4'd8:    s = 8'h01;
        4'd9:    s = 8'h09;
        default: s = 8'h61;
      endcase
    end
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) digit[i] <= BLANK;
    end else if (wr_en) begin
      for (int i = 0; i < 6; i++) begin
        if (wr_addr == 3'(i)) digit[i] <= wr_data;
      end
    end
  end

  always_comb begin
    cur_digit = BLANK;
    cur_dp    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) begin
        cur_digit = digit[i];
        cur_dp    = dp_mask[i];
      end
    end
    seg_next = encode(cur_digit);
    if (cur_dp) seg_next[0] = 1'b0;
  end

  // The latched word only changes in LOAD, so a stalled SEND keeps it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      dwell_cnt  <= '0;
      out_seg    <= 8'hFF;
      out_sel    <= 6'b000001;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          out_seg <= seg_next;
          out_sel <= 6'b000001 << idx;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (!enable) begin
            idx   <= 3'd0;
            state <= S_IDLE;
          end else if (dwell_cnt == '0) begin
            idx        <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            frame_done <= (idx == 3'd5);
            state      <= S_LOAD;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (state == S_SEND);

endmodule

// File: tb/tb_disp_scan_sched.sv
// Self-checking bench for disp_scan_sched with a short dwell.
// Expected words come from a digit-register model snapshotted at each clock edge.
module tb_disp_scan_sched;

  localparam int DWELL  = 4;
  localparam int PERIOD = DWELL + 2;
  localparam int FRAME  = 6 * PERIOD;
  localparam logic [4:0] BLANK = 5'b1_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [5:0] dp_mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_seg;
  logic [5:0] out_sel;
  logic       frame_done;

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0] model_dig [6];
  logic [4:0] snap_dig  [6];
  logic [5:0] snap_dp;
  int         exp_idx;
  logic       prev_v;

  disp_scan_sched #(.DWELL(DWELL), .DWELL_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dp_mask   (dp_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seg   (out_seg),
    .out_sel   (out_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Digit contents and dp mask as they stand just before each edge (what a LOAD would see).
  always @(posedge clk) begin
    snap_dig <= model_dig;
    snap_dp  <= dp_mask;
  end

  function automatic logic [7:0] ref_seg(input logic [4:0] d, input logic dp);
    logic [7:0] glyph [10];
    logic [7:0] s;
    glyph = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    if (d[4])              s = 8'hFF;
    else if (d[3:0] > 4'd9) s = 8'h61;
    else                    s = glyph[int'(d[3:0])];
    if (dp) s = s & 8'hFE;
    return s;
  endfunction

  task automatic restart();
    enable    = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
    dp_mask   = 6'b0;
    rst       = 1'b1;
    for (int i = 0; i < 6; i++) model_dig[i] = BLANK;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    exp_idx = 0;
    prev_v  = 1'b0;
  endtask

  task automatic preload_digits();
    for (int k = 0; k < 6; k++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(k);
      wr_data = 5'($urandom_range(0, 9));
      @(negedge clk);
      model_dig[k] = wr_data;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_word(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        if (exp_idx == target) ok = 1'b1;
        exp_idx = (exp_idx + 1) % 6;
      end
      prev_v = out_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid); end
    n_checks++;
    if (out_seg !== 8'hFF) begin n_fails++; $display("[TB] FAIL reset_seg: got %h, expected ff", out_seg); end
    n_checks++;
    if (out_sel !== 6'b000001) begin n_fails++; $display("[TB] FAIL reset_sel: got %b, expected 000001", out_sel); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_frame_done: got %b, expected 0", frame_done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL idle_no_enable: valid %b, expected 0", out_valid); end
  endtask

  task automatic test_blank_frame();
    int last_rise, last_fd, fd_count;
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    restart();
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL latency_early: valid %b one cycle after enable, expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 6'b000001 || out_seg !== 8'hFF) begin
      n_fails++;
      $display("[TB] FAIL latency_first_word: valid=%b sel=%b seg=%h, expected 1 000001 ff", out_valid, out_sel, out_seg);
    end
    prev_v = 1'b1; exp_idx = 1; last_rise = 0; last_fd = -1; fd_count = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        exp_sel = 6'(1) << exp_idx;
        exp_seg = ref_seg(snap_dig[exp_idx], snap_dp[exp_idx]);
        n_checks++;
        if (out_sel !== exp_sel || out_seg !== exp_seg || out_seg !== 8'hFF) begin
          n_fails++;
          $display("[TB] FAIL blank_word: sel=%b seg=%h, expected sel=%b seg=ff", out_sel, out_seg, exp_sel);
        end
        n_checks++;
        if (cyc - last_rise != PERIOD) begin
          n_fails++;
          $display("[TB] FAIL digit_period: %0d cycles, expected %0d", cyc - last_rise, PERIOD);
        end
        last_rise = cyc;
        exp_idx = (exp_idx + 1) % 6;
      end
      if (frame_done) begin
        n_checks++;
        if (exp_idx != 0) begin n_fails++; $display("[TB] FAIL frame_done_source: pulse after digit %0d, expected after digit 5", (exp_idx + 5) % 6); end
        if (last_fd >= 0) begin
          n_checks++;
          if (cyc - last_fd != FRAME) begin n_fails++; $display("[TB] FAIL frame_period: %0d cycles, expected %0d", cyc - last_fd, FRAME); end
        end
        last_fd = cyc;
        fd_count++;
      end
      prev_v = out_valid;
    end
    n_checks++;
    if (fd_count < 2 || fd_count > 3) begin n_fails++; $display("[TB] FAIL frame_done_count: %0d pulses in 100 cycles, expected 2..3", fd_count); end
  endtask

  task automatic test_digit_patterns();
    logic [4:0] vals [6];
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    bit seen_61, seen_0c;
    vals = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9};
    seen_61 = 1'b0; seen_0c = 1'b0;
    restart();
    dp_mask   = 6'b000100;
    enable    = 1'b1;
    for (int c = 0; c < 140; c++) begin
      if (c < 6)       begin wr_en = 1'b1; wr_addr = 3'(c); wr_data = vals[c]; end
      else if (c == 60) begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'd12; end
      else              wr_en = 1'b0;
      @(negedge clk);
      if (c < 6)   model_dig[c] = vals[c];
      if (c == 60) model_dig[3] = 5'd12;
      if (out_valid && !prev_v) begin
        exp_sel = 6'(1) << exp_idx;
        exp_seg = ref_seg(snap_dig[exp_idx], snap_dp[exp_idx]);
        n_checks++;
        if (out_sel !== exp_sel || out_seg !== exp_seg) begin
          n_fails++;
          $display("[TB] FAIL pattern_word: sel=%b seg=%h, expected sel=%b seg=%h", out_sel, out_seg, exp_sel, exp_seg);
        end
        if (exp_idx == 3 && out_seg === 8'h61) seen_61 = 1'b1;
        if (exp_idx == 2 && out_seg === 8'h0C) seen_0c = 1'b1;
        exp_idx = (exp_idx + 1) % 6;
      end
      prev_v = out_valid;
    end
    n_checks++;
    if (!seen_0c) begin n_fails++; $display("[TB] FAIL dp_on_digit2: seg 0c never shown, expected it"); end
    n_checks++;
    if (!seen_61) begin n_fails++; $display("[TB] FAIL bcd12_shows_E: seg 61 never shown on sel 001000, expected it"); end
  endtask

  task automatic test_random();
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    bit         wrote;
    logic [2:0] a;
    logic [4:0] d;
    restart();
    enable  = 1'b1;
    exp_sel = 6'b0; exp_seg = 8'hFF;
    for (int c = 0; c < 400; c++) begin
      wrote = ($urandom_range(0, 2) == 0);
      a = 3'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 31));
      wr_en = wrote; wr_addr = a; wr_data = d;
      if ($urandom_range(0, 7) == 0) dp_mask = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (wrote && a <= 3'd5) model_dig[a] = d;
      if (out_valid && !prev_v) begin
        exp_sel = 6'(1) << exp_idx;
        exp_seg = ref_seg(snap_dig[exp_idx], snap_dp[exp_idx]);
        exp_idx = (exp_idx + 1) % 6;
      end
      if (out_valid) begin
        n_checks++;
        if (out_sel !== exp_sel || out_seg !== exp_seg) begin
          n_fails++;
          $display("[TB] FAIL random_word: sel=%b seg=%h, expected sel=%b seg=%h", out_sel, out_seg, exp_sel, exp_seg);
        end
      end
      prev_v = out_valid;
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_stall();
    bit ok;
    int rise_at;
    logic [4:0] newval;
    logic [7:0] exp_seg;
    restart();
    preload_digits();
    enable = 1'b1;
    wait_word(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("[TB] FAIL stall_sync1: digit 1 word not seen within 200 cycles"); end
    @(negedge clk);
    prev_v = out_valid;
    out_ready = 1'b0;
    wait_word(2, 200, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("[TB] FAIL stall_sync2: digit 2 word not seen within 200 cycles"); end
    exp_seg = ref_seg(snap_dig[2], snap_dp[2]);
    newval  = 5'(({27'b0, model_dig[2]} + 3) % 10);
    for (int c = 0; c < 20; c++) begin
      if (c == 8)      begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = newval; end
      else if (c == 9) wr_en = 1'b0;
      @(negedge clk);
      if (c == 8) model_dig[2] = newval;
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 6'b000100 || out_seg !== exp_seg) begin
        n_fails++;
        $display("[TB] FAIL stall_hold: cycle %0d valid=%b sel=%b seg=%h, expected 1 000100 %h", c, out_valid, out_sel, out_seg, exp_seg);
      end
    end
    out_ready = 1'b1;
    prev_v = 1'b1;
    rise_at = -1;
    for (int c = 1; c <= 20 && rise_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL stall_accept: valid %b after first ready cycle, expected 0", out_valid); end
      end
      if (out_valid && !prev_v) begin rise_at = c; exp_idx = (exp_idx + 1) % 6; end
      prev_v = out_valid;
    end
    n_checks++;
    if (rise_at != PERIOD) begin n_fails++; $display("[TB] FAIL stall_no_dwell: next word after %0d cycles, expected %0d", rise_at, PERIOD); end
    wait_word(2, 200, ok);
    n_checks++;
    if (!ok || out_seg !== ref_seg(newval, 1'b0)) begin
      n_fails++;
      $display("[TB] FAIL stall_new_value: seg=%h, expected %h next frame", out_seg, ref_seg(newval, 1'b0));
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    restart();
    enable = 1'b1;
    wait_word(3, 200, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("[TB] FAIL drop_sync: digit 3 word not seen within 200 cycles"); end
    out_ready = 1'b0;
    enable    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 6'b001000) begin
        n_fails++;
        $display("[TB] FAIL drop_keeps_valid: valid=%b sel=%b, expected 1 001000", out_valid, out_sel);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL drop_handshake: valid %b, expected 0", out_valid); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL drop_idle: valid=%b frame_done=%b, expected 0 0", out_valid, frame_done);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reenable_early: valid %b, expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 6'b000001 || out_seg !== ref_seg(snap_dig[0], snap_dp[0])) begin
      n_fails++;
      $display("[TB] FAIL reenable_first: valid=%b sel=%b seg=%h, expected 1 000001 %h", out_valid, out_sel, out_seg, ref_seg(snap_dig[0], snap_dp[0]));
    end
  endtask

  task automatic test_reset_mid_dwell();
    bit ok;
    int words;
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    restart();
    preload_digits();
    dp_mask = 6'($urandom);
    enable  = 1'b1;
    wait_word(4, 200, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("[TB] FAIL rst_sync: digit 4 word not seen within 200 cycles"); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_in_dwell: valid %b, expected 0", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_seg !== 8'hFF || out_sel !== 6'b000001 || frame_done !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL async_reset: valid=%b seg=%h sel=%b fd=%b, expected 0 ff 000001 0", out_valid, out_seg, out_sel, frame_done);
    end
    for (int i = 0; i < 6; i++) model_dig[i] = BLANK;
    dp_mask = 6'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 0; prev_v = 1'b0; words = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 0)      begin wr_en = 1'b1; wr_addr = 3'd6; wr_data = 5'd2; end
      else if (c == 1) begin wr_en = 1'b1; wr_addr = 3'd7; wr_data = 5'd8; end
      else             wr_en = 1'b0;
      @(negedge clk);
      if (out_valid && !prev_v) begin
        exp_sel = 6'(1) << exp_idx;
        exp_seg = ref_seg(snap_dig[exp_idx], snap_dp[exp_idx]);
        n_checks++;
        if (out_sel !== exp_sel || out_seg !== exp_seg || out_seg !== 8'hFF) begin
          n_fails++;
          $display("[TB] FAIL post_reset_blank: sel=%b seg=%h, expected sel=%b seg=ff", out_sel, out_seg, exp_sel);
        end
        exp_idx = (exp_idx + 1) % 6;
        words++;
      end
      prev_v = out_valid;
    end
    n_checks++;
    if (words < 6) begin n_fails++; $display("[TB] FAIL post_reset_words: %0d words, expected at least 6", words); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 5'd0;
    dp_mask = 6'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) model_dig[i] = BLANK;
    exp_idx = 0; prev_v = 1'b0;
    test_reset();
    test_blank_frame();
    test_digit_patterns();
    test_random();
    test_stall();
    test_enable_drop();
    test_reset_mid_dwell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
